// File: rtl/multiport_register_file_if.sv
// multiport_register_file_if: byte-strobed write channel and NUM_RD read ports of the register file
interface multiport_register_file_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 16,
  parameter int NUM_RD = 2
);
  localparam int AW = DATA_DEPTH > 1 ? $clog2(DATA_DEPTH) : 1;
  localparam int SW = DATA_WIDTH / 8;
  logic wr_valid;
  logic wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic wr_resp_valid;
  logic wr_resp_err;
  logic [NUM_RD-1:0] rd_en;
  logic [NUM_RD-1:0][AW-1:0] rd_addr;
  logic [NUM_RD-1:0] rd_valid;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;
  logic [NUM_RD-1:0] rd_err;
  modport master (
    output wr_valid, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
    input  wr_ready, wr_resp_valid, wr_resp_err, rd_valid, rd_data, rd_err
  );
  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
    output wr_ready, wr_resp_valid, wr_resp_err, rd_valid, rd_data, rd_err
  );
endinterface

// File: rtl/multiport_register_file.sv
// multiport_register_file: NUM_RD-read, byte-strobed-write register bank with init sequencer and snapshot bus
module multiport_register_file #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 16,
  parameter int NUM_RD = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] init_values,
  input  logic [DATA_DEPTH-1:0] ro_mask,
  input  logic load_req,
  output logic busy,
  output logic load_done,
  output logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] rego,
  multiport_register_file_if.slave bus
);
  localparam int AW = DATA_DEPTH > 1 ? $clog2(DATA_DEPTH) : 1;
  localparam int SW = DATA_WIDTH / 8;
  typedef enum logic {IDLE, LOAD} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic wr_resp_valid_q, wr_resp_valid_d, wr_resp_err_q, wr_resp_err_d;
  logic [RD_LATENCY-1:0][NUM_RD-1:0] rv_q, rv_d, re_q, re_d;
  logic [RD_LATENCY-1:0][NUM_RD-1:0][DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic last, wr_acc, wr_oob, wr_err;
  assign last = cnt_q == AW'(DATA_DEPTH - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    state_d = state_q == LOAD ? (last ? IDLE : LOAD) : (load_req ? LOAD : IDLE);
    cnt_d = state_q == LOAD && !last ? cnt_q + AW'(1) : '0;
  end
  always_comb begin
    busy = state_q == LOAD;
    load_done = state_q == LOAD && last;
    bus.wr_ready = state_q != LOAD;
  end
  assign wr_acc = bus.wr_valid && bus.wr_ready;
  assign wr_oob = 32'(bus.wr_addr) >= 32'(DATA_DEPTH);
  assign wr_err = wr_oob ? 1'b1 : ro_mask[bus.wr_addr];
  // Reads sample regs_q, so a same-cycle write is seen only by later reads
  always_comb begin
    regs_d = regs_q;
    rv_d = '0;
    re_d = '0;
    rdat_d = '0;
    if (busy) regs_d[cnt_q] = init_values[cnt_q];
    else if (wr_acc && !wr_err)
      for (int b = 0; b < SW; b++)
        if (bus.wr_strb[b]) regs_d[bus.wr_addr][8*b +: 8] = bus.wr_data[8*b +: 8];
    wr_resp_valid_d = wr_acc;
    wr_resp_err_d = wr_acc && wr_err;
    for (int p = 0; p < NUM_RD; p++) begin
      rv_d[0][p] = bus.rd_en[p] && !busy;
      re_d[0][p] = bus.rd_en[p] && !busy && 32'(bus.rd_addr[p]) >= 32'(DATA_DEPTH);
      rdat_d[0][p] = 32'(bus.rd_addr[p]) >= 32'(DATA_DEPTH) ? '0 : regs_q[bus.rd_addr[p]];
    end
    for (int s = 1; s < RD_LATENCY; s++) begin
      rv_d[s] = rv_q[s-1];
      re_d[s] = re_q[s-1];
      rdat_d[s] = rdat_q[s-1];
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      regs_q <= '0;
      wr_resp_valid_q <= 1'b0;
      wr_resp_err_q <= 1'b0;
      rv_q <= '0;
      re_q <= '0;
      rdat_q <= '0;
    end else begin
      regs_q <= regs_d;
      wr_resp_valid_q <= wr_resp_valid_d;
      wr_resp_err_q <= wr_resp_err_d;
      rv_q <= rv_d;
      re_q <= re_d;
      rdat_q <= rdat_d;
    end
  assign rego = regs_q;
  assign bus.wr_resp_valid = wr_resp_valid_q;
  assign bus.wr_resp_err = wr_resp_err_q;
  assign bus.rd_valid = rv_q[RD_LATENCY-1];
  assign bus.rd_err = re_q[RD_LATENCY-1];
  assign bus.rd_data = rdat_q[RD_LATENCY-1];
endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised register file that generalises the single-port memory register bank. It provides NUM_RD independent read ports, one byte-strobed write port with a per-write error response, a per-register read-only mask, and a sequential initialisation sequencer that loads init_values one register per cycle after reset or on request. It sits between the core datapath and the top-level configuration logic. The full register contents are always visible on a flat snapshot bus.

## Interface
- DATA_WIDTH, 8, register width in bits; multiple of 8
- DATA_DEPTH, 16, number of registers; need not be a power of two
- NUM_RD, 2, number of read ports (1..4)
- RD_LATENCY, 1, read pipeline depth in cycles (1 or 2)
- Derived: ADDR_WIDTH = $clog2(DATA_DEPTH) (minimum 1); STRB_WIDTH = DATA_WIDTH/8

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- init_values  in  DATA_DEPTH x DATA_WIDTH  values written by the init sequencer
- ro_mask  in  DATA_DEPTH  1 = register is read-only to the write port
- load_req  in  1  single-cycle pulse that starts a reload
- busy  out  1  init sequencer active
- load_done  out  1  one-cycle pulse when the last register has been loaded
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_strb  in  STRB_WIDTH  byte enables
- wr_resp_valid  out  1  write response pulse
- wr_resp_err  out  1  1 = write rejected
- rd_en  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD x ADDR_WIDTH  per-port address
- rd_valid  out  NUM_RD  per-port data valid pulse
- rd_data  out  NUM_RD x DATA_WIDTH  per-port read data
- rd_err  out  NUM_RD  per-port read error (address >= DATA_DEPTH)
- rego  out  DATA_DEPTH x DATA_WIDTH  live register contents

## Operation
- Init FSM has two states, IDLE and LOAD.
  - Reset forces LOAD with counter = 0.
  - In LOAD, the sequencer writes regs[cnt] <= init_values[cnt] and increments cnt each cycle.
  - At cnt == DATA_DEPTH-1 it pulses load_done and goes to IDLE.
  - load_req in IDLE enters LOAD with cnt = 0. load_req during LOAD is ignored and does not restart the sequence.
  - Init writes ignore ro_mask.
- busy = (state == LOAD). wr_ready = !busy.
- Write: on an accepted write (wr_valid && wr_ready), the response is registered and appears the next cycle as wr_resp_valid = 1.
  - Error, no update: if wr_addr >= DATA_DEPTH or ro_mask[wr_addr] = 1, then wr_resp_err = 1 and the register is unchanged.
  - Normal update: otherwise each byte b with wr_strb[b] = 1 is replaced, and bytes with wr_strb[b] = 0 are kept. wr_resp_err = 0.
  - wr_strb = 0 on a legal address is a successful no-op with err = 0.
- Read: each port is independent, and all ports may address the same register.
  - If rd_addr >= DATA_DEPTH: rd_err = 1 and rd_data = 0.
  - If busy: the request is dropped and no rd_valid is produced.
- Read and write of the same address in the same cycle return the old value (read-before-write).
- rego reflects the register array directly, one cycle after any update.

## Timing
- Reset values:
  - regs = 0; busy = 1 (LOAD, cnt = 0); load_done = 0.
  - wr_resp_valid = 0, wr_resp_err = 0.
  - rd_valid = 0, rd_data = 0, rd_err = 0; all read pipeline stages cleared.
- First cycle after reset release: the sequencer loads register 0.
  - load_done pulses in cycle DATA_DEPTH (1-based).
  - busy falls in the following cycle.
  - Total: DATA_DEPTH cycles of busy after reset release.
- Write response latency: 1 cycle. The updated value is readable by a read issued in the cycle after acceptance.
- Read latency: RD_LATENCY cycles from rd_en to rd_valid, fully pipelined, one request per port per cycle.
  - For RD_LATENCY = 2, the first stage samples the array and the second stage registers it.
  - A read accepted on the cycle before load_req still completes with the pre-load data.
- Reset mid-operation: pending write responses and in-flight reads are discarded with no valid pulses, and the sequencer restarts at cnt = 0.
- rd_valid, load_done and wr_resp_valid are single-cycle pulses.

## Test plan
- Reset release with init_values[i] = i+0x10, DEPTH = 16:
  - busy stays high for 16 cycles, then load_done pulses once.
  - Afterwards rego[i] = i+0x10 and rd_en is ignored while busy.
- Write 0xA5 to addr 3 with strb = 1 and ro_mask = 0:
  - wr_resp_valid = 1, err = 0 in the next cycle.
  - A port-0 read of addr 3 returns 0xA5 after RD_LATENCY cycles.
- ro_mask[5] = 1, write 0xFF to addr 5:
  - wr_resp_err = 1 and regs[5] keeps its init value.
  - Repeat with DATA_DEPTH = 12 and addr 13: err = 1.
- DATA_WIDTH = 32, regs[2] = 0x11223344, write 0xAABBCCDD with strb = 0101:
  - regs[2] = 0x11BB33DD.
- Same-cycle write of 0x77 to addr 7 plus reads of addr 7 on both ports:
  - Both ports return the old value.
  - Reads in the next cycle return 0x77.
  - With RD_LATENCY = 2, rd_valid lands exactly 2 cycles after rd_en.
- Other boundary cases:
  - load_req while idle after writes restores all init values in DEPTH cycles and drops writes with wr_ready = 0.
  - Asserting rst_n low mid-LOAD clears regs and restarts the sequence.
